forward_hazard_unit: RTL and testbench

Parametrised successor to the EX-stage forwarding unit. Selects operand sources for N source operands of the instruction in EX, forwarding from EX/MEM, MEM/WB or the final stage of the pipelined multi-cycle multiplier. Owns a scoreboard that tracks in-flight multiplies. Raises a stall for load-use, RAW-on-pending-multiply and WAW-on-pending-multiply hazards. Sits beside the ID/EX register and drives the operand muxes and the pipeline hold logic.

---
 rtl/fwd_pkg.sv | 9 +
 rtl/forward_hazard_unit_if.sv | 29 ++
 rtl/mul_scoreboard.sv | 45 ++++
 rtl/forward_hazard_unit.sv | 52 +++++
 tb/tb_forward_hazard_unit.sv | 130 +++++++++++++
 5 files changed

// File: rtl/fwd_pkg.sv
// fwd_pkg: operand-source encodings and multiplier latency bounds for the forwarding unit
package fwd_pkg;
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MUL   = 2'b11;
  localparam int MUL_LAT_MIN = 3;
  localparam int MUL_LAT_MAX = 8;
endpackage

// File: rtl/forward_hazard_unit_if.sv
// forward_hazard_unit_if: EX-stage operand/producer bundle and forwarding/stall results
interface forward_hazard_unit_if #(parameter int ADDR_W = 5, parameter int NUM_SRC = 2);
  logic                       ex_valid;
  logic [NUM_SRC*ADDR_W-1:0]  ex_rs;
  logic [NUM_SRC-1:0]         ex_rs_used;
  logic [ADDR_W-1:0]          ex_rd;
  logic                       ex_reg_write;
  logic                       ex_is_mul;
  logic [ADDR_W-1:0]          ex_mem_rd;
  logic                       ex_mem_reg_write;
  logic                       ex_mem_is_load;
  logic [ADDR_W-1:0]          mem_wb_rd;
  logic                       mem_wb_reg_write;
  logic [2*NUM_SRC-1:0]       fwd_sel;
  logic                       stall;
  logic                       mul_wb_valid;
  logic [ADDR_W-1:0]          mul_wb_rd;
  logic                       mul_busy;
  modport master(
    output ex_valid, ex_rs, ex_rs_used, ex_rd, ex_reg_write, ex_is_mul,
           ex_mem_rd, ex_mem_reg_write, ex_mem_is_load, mem_wb_rd, mem_wb_reg_write,
    input  fwd_sel, stall, mul_wb_valid, mul_wb_rd, mul_busy
  );
  modport slave(
    input  ex_valid, ex_rs, ex_rs_used, ex_rd, ex_reg_write, ex_is_mul,
           ex_mem_rd, ex_mem_reg_write, ex_mem_is_load, mem_wb_rd, mem_wb_reg_write,
    output fwd_sel, stall, mul_wb_valid, mul_wb_rd, mul_busy
  );
endinterface

// File: rtl/mul_scoreboard.sv
// mul_scoreboard: tracks in-flight multiplies and flags addresses still pending in stages 1..MUL_LAT-1
module mul_scoreboard #(
  parameter int ADDR_W  = 5,
  parameter int MUL_LAT = 4,
  parameter int NUM_CMP = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic [ADDR_W-1:0]                in_rd,
  input  logic [NUM_CMP-1:0][ADDR_W-1:0]   cmp_addr,
  output logic [NUM_CMP-1:0]               pend,
  output logic                             out_valid,
  output logic [ADDR_W-1:0]                out_rd,
  output logic                             busy
);
  logic [MUL_LAT-1:0]             vld_q, vld_d;
  logic [MUL_LAT-1:0][ADDR_W-1:0] rd_q, rd_d;
  logic [NUM_CMP-1:0][MUL_LAT-2:0] hit;
  always_comb begin
    vld_d = {vld_q[MUL_LAT-2:0], in_valid};
    rd_d  = {rd_q[MUL_LAT-2:0], in_rd};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      rd_q  <= '0;
    end else begin
      vld_q <= vld_d;
      rd_q  <= rd_d;
    end
  end
  // the final stage is excluded: its result is forwardable, so it never blocks
  always_comb begin
    hit  = '0;
    pend = '0;
    for (int c = 0; c < NUM_CMP; c++) begin
      for (int s = 0; s < MUL_LAT-1; s++) hit[c][s] = vld_q[s] && rd_q[s] == cmp_addr[c];
      pend[c] = |hit[c];
    end
  end
  assign out_valid = vld_q[MUL_LAT-1];
  assign out_rd    = vld_q[MUL_LAT-1] ? rd_q[MUL_LAT-1] : '0;
  assign busy      = |vld_q;
endmodule

// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit: EX operand-source select and load-use / multiply RAW / WAW stall generation
module forward_hazard_unit
  import fwd_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2,
  parameter int MUL_LAT = 4
) (
  input logic                 clk,
  input logic                 rst,
  forward_hazard_unit_if.slave bus
);
  logic [NUM_SRC:0][ADDR_W-1:0] cmp;
  logic [NUM_SRC:0]             pend;
  logic [NUM_SRC-1:0]           lu, raw;
  logic [NUM_SRC-1:0][1:0]      sel;
  logic                         waw, issue, sb_valid, sb_busy;
  logic [ADDR_W-1:0]            sb_rd;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [ADDR_W-1:0] rs;
    logic              used, em, mm, wb;
    assign rs      = bus.ex_rs[i*ADDR_W +: ADDR_W];
    assign used    = bus.ex_rs_used[i] && rs != '0;
    assign em      = used && bus.ex_mem_reg_write && bus.ex_mem_rd == rs;
    assign mm      = used && sb_valid && sb_rd == rs;
    assign wb      = used && bus.mem_wb_reg_write && bus.mem_wb_rd == rs;
    assign cmp[i]  = used ? rs : '0;
    assign lu[i]   = em && bus.ex_mem_is_load;
    assign raw[i]  = pend[i];
    assign sel[i]  = em ? FWD_EXMEM : mm ? FWD_MUL : wb ? FWD_MEMWB : FWD_RF;
  end
  // address 0 never matches: valid scoreboard entries always carry a nonzero rd
  assign cmp[NUM_SRC] = bus.ex_reg_write ? bus.ex_rd : '0;
  assign waw          = pend[NUM_SRC];
  assign bus.stall    = bus.ex_valid && (|lu || |raw || waw);
  assign issue        = bus.ex_valid && bus.ex_is_mul && bus.ex_reg_write && bus.ex_rd != '0 && !bus.stall;
  assign bus.fwd_sel  = sel;
  assign bus.mul_wb_valid = sb_valid;
  assign bus.mul_wb_rd    = sb_rd;
  assign bus.mul_busy     = sb_busy;
  mul_scoreboard #(.ADDR_W(ADDR_W), .MUL_LAT(MUL_LAT), .NUM_CMP(NUM_SRC+1)) u_sb (
    .clk(clk),
    .rst(rst),
    .in_valid(issue),
    .in_rd(bus.ex_rd),
    .cmp_addr(cmp),
    .pend(pend),
    .out_valid(sb_valid),
    .out_rd(sb_rd),
    .busy(sb_busy)
  );
endmodule

// File: tb/tb_forward_hazard_unit.sv
// tb_forward_hazard_unit: directed scenario checks for forwarding, stalls and the multiply scoreboard
module tb_forward_hazard_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  forward_hazard_unit_if #(.ADDR_W(5), .NUM_SRC(2)) bus();
  forward_hazard_unit #(.ADDR_W(5), .NUM_SRC(2), .MUL_LAT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic idle();
    bus.ex_valid = 0; bus.ex_rs = '0; bus.ex_rs_used = '0; bus.ex_rd = '0;
    bus.ex_reg_write = 0; bus.ex_is_mul = 0;
    bus.ex_mem_rd = '0; bus.ex_mem_reg_write = 0; bus.ex_mem_is_load = 0;
    bus.mem_wb_rd = '0; bus.mem_wb_reg_write = 0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic src(input int i, input logic [4:0] r);
    bus.ex_valid = 1;
    bus.ex_rs[i*5 +: 5] = r;
    bus.ex_rs_used[i] = 1;
  endtask
  task automatic mul(input logic [4:0] rd);
    idle();
    bus.ex_valid = 1; bus.ex_is_mul = 1; bus.ex_reg_write = 1; bus.ex_rd = rd;
  endtask
  task automatic test_reset();
    idle();
    bus.ex_mem_rd = 5'd3; bus.ex_mem_reg_write = 1; src(0, 5'd3);
    step();
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", bus.stall); end
    total++; if (bus.mul_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", bus.mul_busy); end
    total++; if (bus.mul_wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got=%0b exp=0", bus.mul_wb_valid); end
    total++; if (bus.mul_wb_rd !== 5'd0) begin bad++; $display("FAIL reset_wb_rd got=%0d exp=0", bus.mul_wb_rd); end
    total++; if (bus.fwd_sel !== 4'b0010) begin bad++; $display("FAIL reset_fwd_sel got=%b exp=0010", bus.fwd_sel); end
    rst = 0;
    idle();
    step();
  endtask
  task automatic test_forward();
    idle(); bus.ex_mem_rd = 5'd5; bus.ex_mem_reg_write = 1; src(0, 5'd5); #1;
    total++; if (bus.fwd_sel !== 4'b0010 || bus.stall !== 1'b0) begin bad++; $display("FAIL fwd_exmem got sel=%b stall=%0b exp sel=0010 stall=0", bus.fwd_sel, bus.stall); end
    bus.ex_mem_rd = 5'd4; bus.mem_wb_rd = 5'd5; bus.mem_wb_reg_write = 1; #1;
    total++; if (bus.fwd_sel !== 4'b0001) begin bad++; $display("FAIL fwd_memwb got=%b exp=0001", bus.fwd_sel); end
    bus.ex_mem_rd = 5'd5; #1;
    total++; if (bus.fwd_sel !== 4'b0010) begin bad++; $display("FAIL fwd_priority got=%b exp=0010", bus.fwd_sel); end
    bus.ex_rs_used = 2'b00; #1;
    total++; if (bus.fwd_sel !== 4'b0000) begin bad++; $display("FAIL fwd_unused got=%b exp=0000", bus.fwd_sel); end
    idle(); bus.ex_mem_rd = 5'd0; bus.ex_mem_reg_write = 1; bus.ex_mem_is_load = 1; src(0, 5'd0); src(1, 5'd0); #1;
    total++; if (bus.fwd_sel !== 4'b0000 || bus.stall !== 1'b0) begin bad++; $display("FAIL fwd_x0 got sel=%b stall=%0b exp sel=0000 stall=0", bus.fwd_sel, bus.stall); end
    idle(); step();
  endtask
  task automatic test_load_use();
    idle(); bus.ex_mem_rd = 5'd6; bus.ex_mem_reg_write = 1; bus.ex_mem_is_load = 1; src(1, 5'd6); bus.ex_valid = 0; #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL lu_invalid got=%0b exp=0", bus.stall); end
    bus.ex_valid = 1; #1;
    total++; if (bus.stall !== 1'b1 || bus.fwd_sel[3:2] !== 2'b10) begin bad++; $display("FAIL lu_stall got stall=%0b sel=%b exp stall=1 sel=10", bus.stall, bus.fwd_sel[3:2]); end
    step();
    bus.ex_mem_reg_write = 0; bus.ex_mem_is_load = 0; bus.mem_wb_rd = 5'd6; bus.mem_wb_reg_write = 1; #1;
    total++; if (bus.stall !== 1'b0 || bus.fwd_sel[3:2] !== 2'b01) begin bad++; $display("FAIL lu_after got stall=%0b sel=%b exp stall=0 sel=01", bus.stall, bus.fwd_sel[3:2]); end
    idle(); step();
  endtask
  task automatic test_mul_raw();
    mul(5'd7); #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL raw_issue got=%0b exp=0", bus.stall); end
    step();
    idle(); src(0, 5'd7); bus.ex_reg_write = 1; bus.ex_rd = 5'd9; #1;
    for (int k = 0; k < 3; k++) begin
      total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL raw_stall%0d got=%0b exp=1", k, bus.stall); end
      step();
    end
    total++; if (bus.stall !== 1'b0 || bus.fwd_sel[1:0] !== 2'b11) begin bad++; $display("FAIL raw_fwd got stall=%0b sel=%b exp stall=0 sel=11", bus.stall, bus.fwd_sel[1:0]); end
    total++; if (bus.mul_wb_valid !== 1'b1 || bus.mul_wb_rd !== 5'd7) begin bad++; $display("FAIL raw_wb got v=%0b rd=%0d exp v=1 rd=7", bus.mul_wb_valid, bus.mul_wb_rd); end
    idle(); step();
    total++; if (bus.mul_busy !== 1'b0) begin bad++; $display("FAIL raw_drain got=%0b exp=0", bus.mul_busy); end
  endtask
  task automatic test_mul_waw();
    mul(5'd8); step();
    idle(); bus.ex_valid = 1; bus.ex_reg_write = 1; bus.ex_rd = 5'd8; #1;
    for (int k = 0; k < 3; k++) begin
      total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL waw_stall%0d got=%0b exp=1", k, bus.stall); end
      step();
    end
    total++; if (bus.stall !== 1'b0 || bus.mul_wb_rd !== 5'd8) begin bad++; $display("FAIL waw_release got stall=%0b rd=%0d exp stall=0 rd=8", bus.stall, bus.mul_wb_rd); end
    idle(); step();
  endtask
  task automatic test_back_to_back();
    idle(); #1;
    total++; if (bus.mul_busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%0b exp=0", bus.mul_busy); end
    for (int j = 0; j < 4; j++) begin
      mul(5'(10 + j)); #1;
      total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL b2b_stall%0d got=%0b exp=0", j, bus.stall); end
      step();
      total++; if (bus.mul_busy !== 1'b1) begin bad++; $display("FAIL b2b_busy%0d got=%0b exp=1", j, bus.mul_busy); end
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      total++; if (bus.mul_busy !== 1'b1 || bus.mul_wb_valid !== 1'b1 || bus.mul_wb_rd !== 5'(10 + k)) begin bad++; $display("FAIL b2b_wb%0d got busy=%0b v=%0b rd=%0d exp busy=1 v=1 rd=%0d", k, bus.mul_busy, bus.mul_wb_valid, bus.mul_wb_rd, 10 + k); end
      step();
    end
    total++; if (bus.mul_busy !== 1'b0) begin bad++; $display("FAIL b2b_done got=%0b exp=0", bus.mul_busy); end
  endtask
  task automatic test_mid_reset();
    mul(5'd9); step();
    idle(); step();
    rst = 1; mul(5'd20); step();
    rst = 0; idle(); src(0, 5'd9); #1;
    total++; if (bus.mul_busy !== 1'b0 || bus.mul_wb_valid !== 1'b0) begin bad++; $display("FAIL mrst_clear got busy=%0b v=%0b exp 0 0", bus.mul_busy, bus.mul_wb_valid); end
    total++; if (bus.stall !== 1'b0 || bus.fwd_sel !== 4'b0000) begin bad++; $display("FAIL mrst_consumer got stall=%0b sel=%b exp 0 0000", bus.stall, bus.fwd_sel); end
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (bus.mul_wb_valid !== 1'b0 || bus.mul_busy !== 1'b0) begin bad++; $display("FAIL mrst_quiet%0d got v=%0b busy=%0b exp 0 0", k, bus.mul_wb_valid, bus.mul_busy); end
    end
    idle();
  endtask
  initial begin
    idle();
    test_reset();
    test_forward();
    test_load_use();
    test_mul_raw();
    test_mul_waw();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
